mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the number of WAIT cycles without mem_ack after which an access aborts (range 1..255).
REQ-002 Parameter STARVE_LIM, default 2, is the number of consecutive fetch losses after which fetch wins the next arbitration (range 1..3).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  instruction-fetch request; held until if_gnt.
REQ-006 if_addr  in  16  fetch address (PC).
REQ-007 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
REQ-009 if_rdata  out  16  fetched instruction.
REQ-010 d_req  in  1  data request (LDR/STR); held until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  16  data address.
REQ-013 d_wdata  in  16  store data.
REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  out  1  one-cycle pulse: data access complete; d_rdata is valid for loads.
REQ-016 d_rdata  out  16  load data.
REQ-017 mem_req, mem_we  out  1, 1  shared memory port request and write enable.
REQ-018 mem_addr, mem_wdata  out  16, 16  shared port address and write data.
REQ-019 mem_ack  in  1  memory completion; qualifies mem_rdata.
REQ-020 mem_rdata  in  16  memory read data.
REQ-021 busy  out  1  high while an access is outstanding (state WAIT).
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 The FSM shall have two states: IDLE and WAIT.
REQ-024 In IDLE with any request pending, the next edge shall enter WAIT, latch the winner's addr/we/wdata into mem_*, set mem_req=1, record the owner, and pulse the winner's gnt in the following cycle.
REQ-025 Arbitration: data wins ties unless starve_cnt==STARVE_LIM, in which case fetch wins.
REQ-026 starve_cnt shall increment, saturating, when fetch loses a tie, and clear when fetch is granted.
REQ-027 Fetch requests shall never use mem_we=1.
REQ-028 In WAIT, mem_req, mem_we, mem_addr and mem_wdata shall remain stable, and the loser's request shall not be granted.
REQ-029 On an edge with mem_ack=1 in WAIT, the FSM shall return to IDLE with mem_req=0.
REQ-030 On that same edge, the owner's rvalid shall pulse next cycle with rdata=mem_rdata (loads/fetches) or rdata=0 (stores).
REQ-031 Minimum access occupancy shall be 2 cycles (grant to rvalid), and back-to-back grants shall be at least 2 cycles apart.
REQ-032 wait_cnt shall clear on entering WAIT and increment each WAIT cycle without ack.
REQ-033 When wait_cnt reaches MAX_WAIT, the FSM shall return to IDLE, drop mem_req, pulse the owner's rvalid with rdata=0, and set err.
REQ-034 If mem_ack and the timeout coincide, ack shall win: normal completion, err unchanged.
REQ-035 mem_ack while in IDLE shall be ignored.
REQ-036 A request dropped before its gnt shall have no effect, and no pending state shall be kept.
REQ-037 busy shall equal (state==WAIT).
REQ-038 rvalid and gnt for both requesters shall never be high in the same cycle as each other's counterpart.

Reset
REQ-039 reset=0 shall asynchronously force: state=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; all gnt/rvalid=0; if_rdata=0; d_rdata=0; starve_cnt=0; wait_cnt=0; busy=0; err=0.
REQ-040 Reset during WAIT shall abandon the access with no rvalid pulse.
REQ-041 After reset deasserts, the first grant shall occur no earlier than the second rising edge.

Verification
REQ-042 Fetch only: if_req, if_addr=0x0010; mem_ack 3 cycles after mem_req with mem_rdata=0x1C08 -> if_gnt 1 cycle, mem_addr=0x0010, if_rvalid with if_rdata=0x1C08, busy low afterwards.
REQ-043 Tie with STARVE_LIM=2: if_req and d_req held continuously, immediate acks -> grant order D, D, IF, D, D, IF.
REQ-044 Store: d_req, d_we=1, d_addr=0x0200, d_wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF, d_rvalid with d_rdata=0; if_rvalid stays 0.
REQ-045 Timeout with MAX_WAIT=4: no mem_ack -> mem_req drops after 4 WAIT cycles, d_rvalid with d_rdata=0, err=1 until reset; ack on the 4th cycle -> normal completion, err=0.
REQ-046 Reset mid-WAIT: assert reset=0 two cycles after grant -> all outputs 0 immediately, no rvalid pulse; a request after release is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data requests onto one shared memory port,
// with fetch starvation protection and a per-access timeout.
module mem_arbiter #(
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic        rdy, owner_d, start, pick_d, timeout, done;
    logic [1:0]  starve_cnt;
    logic [7:0]  wait_cnt;
    logic [15:0] rsp;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // rdy holds off the first grant until one edge after reset release
    always_comb begin
        start    = state == IDLE && rdy && (if_req || d_req);
        pick_d   = d_req && !(if_req && starve_cnt == 2'(STARVE_LIM));
        timeout  = state == WAIT && !mem_ack && wait_cnt == 8'(MAX_WAIT - 1);
        done     = state == WAIT && (mem_ack || timeout);
        state_nx = start ? WAIT : done ? IDLE : state;
        rsp      = (mem_ack && !mem_we) ? mem_rdata : '0;
    end

    always_comb busy = state == WAIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy        <= 1'b0;
            owner_d    <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            rdy       <= 1'b1;
            if_gnt    <= start && !pick_d;
            d_gnt     <= start && pick_d;
            if_rvalid <= done && !owner_d;
            d_rvalid  <= done && owner_d;
            if (start) begin
                mem_req    <= 1'b1;
                mem_we     <= pick_d && d_we;
                mem_addr   <= pick_d ? d_addr : if_addr;
                mem_wdata  <= pick_d ? d_wdata : '0;
                owner_d    <= pick_d;
                wait_cnt   <= '0;
                starve_cnt <= !pick_d ? '0 :
                              (if_req && starve_cnt != 2'(STARVE_LIM)) ? starve_cnt + 2'd1 : starve_cnt;
            end else if (done) begin
                mem_req <= 1'b0;
                err     <= err | timeout;
                if (owner_d) d_rdata <= rsp;
                else if_rdata <= rsp;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model
// and counted requesters that drop their request once granted.
module tb_mem_arbiter;
    typedef struct packed {logic d; logic we; logic [15:0] addr; logic [15:0] wdata;} gexp_t;
    typedef struct packed {logic d; logic [15:0] data;} rexp_t;

    logic clk = 0, rst_n = 0;
    logic if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy, err;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    int checks = 0, failures = 0;
    int if_left = 0, d_left = 0, mem_lat = 0, mcnt = 0;
    logic stray_ack = 0, use_fix = 0;
    logic [15:0] fix_data = 0;
    gexp_t gq[$];
    gexp_t cur = '0;
    rexp_t rq[$];
    rexp_t r;

    mem_arbiter #(.MAX_WAIT(4), .STARVE_LIM(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic d, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        gq.push_back('{d: d, we: we, addr: addr, wdata: wdata});
    endtask

    task automatic push_r(input logic d, input logic [15:0] data);
        rq.push_back('{d: d, data: data});
    endtask

    // load or fetch whose memory data follows the model's address mapping
    task automatic push_ld(input logic d, input logic [15:0] addr);
        push_g(d, 1'b0, addr, 16'h0);
        push_r(d, addr ^ 16'hA5A5);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((gq.size() != 0 || rq.size() != 0 || busy || if_req || d_req) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", n < budget, 1);
    endtask

    task automatic req_len(output int n);
        int k = 0;
        n = 0;
        while (k < 40 && !(n > 0 && !mem_req)) begin
            tick();
            n += int'(mem_req);
            k++;
        end
    endtask

    task automatic reset_dut();
        rst_n = 0;
        #1;
        chk("rst_ctl", {mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy, err}, 0);
        chk("rst_addr", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        tick();
        tick();
        rst_n = 1;
    endtask

    // memory model: ack mem_lat cycles after mem_req rises (0 = never)
    initial forever begin
        @(posedge clk);
        #1;
        mcnt = mem_req ? mcnt + 1 : 0;
        mem_ack = stray_ack || (mem_req && mem_lat > 0 && mcnt == mem_lat);
        mem_rdata = use_fix ? fix_data : mem_addr ^ 16'hA5A5;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (if_gnt) begin if_left--; if_addr++; end
        if (d_gnt) begin d_left--; d_addr++; end
        if_req = if_left > 0;
        d_req = d_left > 0;
    end

    always @(negedge clk) begin
        chk("busy_eq", busy, mem_req);
        if (if_gnt || d_gnt) begin
            chk("gnt_mix", {if_gnt & d_gnt, (if_gnt | d_gnt) & (if_rvalid | d_rvalid)}, 0);
            if (gq.size() == 0) chk("gnt_extra", {if_gnt, d_gnt}, 0);
            else begin
                cur = gq.pop_front();
                chk("gnt_who", {if_gnt, d_gnt}, {!cur.d, cur.d});
                chk("gnt_req", {mem_req, busy}, 2'b11);
            end
        end
        if (mem_req) chk("mem_hold", {mem_we, mem_addr, mem_wdata & {16{cur.we}}}, {cur.we, cur.addr, cur.wdata});
        if (if_rvalid || d_rvalid) begin
            if (rq.size() == 0) chk("rv_extra", {if_rvalid, d_rvalid}, 0);
            else begin
                r = rq.pop_front();
                chk("rv_who", {if_rvalid, d_rvalid}, {!r.d, r.d});
                chk("rv_data", d_rvalid ? d_rdata : if_rdata, r.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        tick();
        reset_dut();
        tick();

        // fetch only, request pending across reset release
        rst_n = 0;
        if_addr = 16'h0010; if_left = 1; mem_lat = 3; use_fix = 1; fix_data = 16'h1C08;
        push_g(0, 0, 16'h0010, 16'h0); push_r(0, 16'h1C08);
        tick(); tick();
        rst_n = 1;
        tick();
        chk("gnt_early", {if_gnt, mem_req}, 0);
        tick();
        chk("gnt_first", if_gnt, 1);
        wait_done(40);
        chk("fetch_idle", {busy, mem_req}, 0);
        use_fix = 0;

        // ack while idle is ignored
        stray_ack = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_ack", {busy, mem_req, if_rvalid, d_rvalid, err}, 0);
        end
        stray_ack = 0;
        tick();

        // continuous tie with immediate acks: D, D, IF, D, D, IF
        mem_lat = 1; d_we = 0; d_addr = 16'h0100; if_addr = 16'h0040;
        push_ld(1, 16'h0100); push_ld(1, 16'h0101); push_ld(0, 16'h0040);
        push_ld(1, 16'h0102); push_ld(1, 16'h0103); push_ld(0, 16'h0041);
        d_left = 4; if_left = 2;
        wait_done(100);

        // store completes with zero read data
        d_we = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF; mem_lat = 2;
        push_g(1, 1, 16'h0200, 16'hBEEF); push_r(1, 16'h0);
        d_left = 1;
        wait_done(40);
        d_we = 0;

        // ack on the last allowed wait cycle wins over the timeout
        d_addr = 16'h0300; mem_lat = 4;
        push_ld(1, 16'h0300);
        d_left = 1;
        req_len(n);
        chk("ack4_len", n, 4);
        wait_done(40);
        chk("ack4_err", err, 0);

        // timeout: no ack at all
        d_addr = 16'h0310; mem_lat = 0;
        push_g(1, 0, 16'h0310, 16'h0); push_r(1, 16'h0);
        d_left = 1;
        req_len(n);
        chk("tmo_len", n, 4);
        wait_done(40);
        chk("tmo_err", err, 1);
        mem_lat = 1; if_addr = 16'h0050;
        push_ld(0, 16'h0050);
        if_left = 1;
        wait_done(40);
        chk("err_sticky", err, 1);

        // reset two cycles after grant abandons the access
        mem_lat = 0; d_addr = 16'h0400;
        push_g(1, 0, 16'h0400, 16'h0);
        d_left = 1;
        k = 0;
        while (!d_gnt && k < 20) begin tick(); k++; end
        chk("mid_gnt", d_gnt, 1);
        tick(); tick();
        reset_dut();
        tick();
        chk("mid_norv", {if_rvalid, d_rvalid, busy}, 0);
        mem_lat = 1; d_addr = 16'h0410;
        push_ld(1, 16'h0410);
        d_left = 1;
        wait_done(40);
        chk("post_rst_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
